// File: rtl/mbist_pkg.sv
// Shared types for the MBIST March C- controller: FSM states, op codes and the element table.
package mbist_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

    // Bit 1 marks a read, bit 0 selects the inverted ("1") background.
    typedef enum logic [1:0] {
        OpW0 = 2'b00,
        OpW1 = 2'b01,
        OpR0 = 2'b10,
        OpR1 = 2'b11
    } op_t;

    typedef struct packed {
        logic [1:0] op_cnt;
        op_t        op0;
        op_t        op1;
        logic       down;
    } elem_t;

    localparam int unsigned ElemCount = 6;

    // Concatenated E5 down to E0 so that ElemTable[i] is element Ei.
    localparam elem_t [ElemCount-1:0] ElemTable = {
        elem_t'{2'd1, OpR0, OpR0, 1'b0},
        elem_t'{2'd2, OpR1, OpW0, 1'b1},
        elem_t'{2'd2, OpR0, OpW1, 1'b1},
        elem_t'{2'd2, OpR1, OpW0, 1'b0},
        elem_t'{2'd2, OpR0, OpW1, 1'b0},
        elem_t'{2'd1, OpW0, OpW0, 1'b0}
    };

    function automatic logic op_is_read(input op_t op);
        return op[1];
    endfunction

    function automatic logic op_is_one(input op_t op);
        return op[0];
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Linear up/down address counter for the March sequencer, split into {row, col}.
module mbist_addr_gen
    import mbist_pkg::*;
#(
    parameter int unsigned ROW_ADDR_BITS = 2,
    parameter int unsigned COL_ADDR_BITS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     load_down,
    input  logic                     step,
    input  logic                     down,
    output logic [ROW_ADDR_BITS-1:0] row,
    output logic [COL_ADDR_BITS-1:0] col,
    output logic                     last
);
    localparam int unsigned AddrBits = ROW_ADDR_BITS + COL_ADDR_BITS;

    logic [AddrBits-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else if (load) begin
            addr_q <= load_down ? '1 : '0;
        end else if (step) begin
            addr_q <= down ? addr_q - AddrBits'(1) : addr_q + AddrBits'(1);
        end
    end

    assign last = down ? (addr_q == '0) : (addr_q == '1);
    assign row  = addr_q[AddrBits-1:COL_ADDR_BITS];
    assign col  = addr_q[COL_ADDR_BITS-1:0];

endmodule

// File: rtl/mbist_march_ctrl.sv
// MBIST March C- controller: drives one 2D memory and logs read mismatches.
// Define MBIST_CHECKERBOARD_EN to append a second pass on a row/col checkerboard background.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int unsigned ROW_ADDR_BITS  = 2,
    parameter int unsigned COL_ADDR_BITS  = 2,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned FAIL_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      fail,
    output logic [FAIL_CNT_WIDTH-1:0] fail_count,
    output logic [ROW_ADDR_BITS-1:0]  first_fail_row,
    output logic [COL_ADDR_BITS-1:0]  first_fail_col,
    output logic [DATA_WIDTH-1:0]     first_fail_data,
    output logic                      mem_wr_en,
    output logic [ROW_ADDR_BITS-1:0]  mem_row,
    output logic [COL_ADDR_BITS-1:0]  mem_col,
    output logic [DATA_WIDTH-1:0]     mem_data_in,
    input  logic [DATA_WIDTH-1:0]     mem_data_out
);
    localparam logic [2:0] LastElem = 3'(ElemCount - 1);

    state_t                   state_q, state_d;
    logic [2:0]               elem_q, elem_d, elem_nxt;
    logic                     op_idx_q, op_idx_d;
    elem_t                    cur_elem;
    op_t                      cur_op;
    logic                     last_op, addr_last, run;
    logic                     load, load_down, step, clear;
    logic [ROW_ADDR_BITS-1:0] row;
    logic [COL_ADDR_BITS-1:0] col;
    logic [DATA_WIDTH-1:0]    pat, op_data;

    logic                     rd_valid_q;
    logic [ROW_ADDR_BITS-1:0] rd_row_q;
    logic [COL_ADDR_BITS-1:0] rd_col_q;
    logic [DATA_WIDTH-1:0]    rd_exp_q;

    assign cur_elem = ElemTable[elem_q];
    assign cur_op   = op_idx_q ? cur_elem.op1 : cur_elem.op0;
    assign last_op  = op_idx_q || (cur_elem.op_cnt == 2'd1);
    assign elem_nxt = (elem_q == LastElem) ? 3'd0 : elem_q + 3'd1;
    assign run      = (state_q == StRun);

`ifdef MBIST_CHECKERBOARD_EN
    logic pass_q, pass_d;
    assign pat = !pass_q ? '0 :
                 (row[0] ^ col[0]) ? {DATA_WIDTH/2{2'b10}} : {DATA_WIDTH/2{2'b01}};
`else
    assign pat = '0;
`endif

    mbist_addr_gen #(
        .ROW_ADDR_BITS (ROW_ADDR_BITS),
        .COL_ADDR_BITS (COL_ADDR_BITS)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_down (load_down),
        .step      (step),
        .down      (cur_elem.down),
        .row       (row),
        .col       (col),
        .last      (addr_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            elem_q   <= '0;
            op_idx_q <= 1'b0;
`ifdef MBIST_CHECKERBOARD_EN
            pass_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            elem_q   <= elem_d;
            op_idx_q <= op_idx_d;
`ifdef MBIST_CHECKERBOARD_EN
            pass_q   <= pass_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        op_idx_d  = op_idx_q;
        load      = 1'b0;
        load_down = 1'b0;
        step      = 1'b0;
        clear     = 1'b0;
`ifdef MBIST_CHECKERBOARD_EN
        pass_d    = pass_q;
`endif
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StRun;
                    elem_d    = '0;
                    op_idx_d  = 1'b0;
                    load      = 1'b1;
                    load_down = ElemTable[0].down;
                    clear     = 1'b1;
`ifdef MBIST_CHECKERBOARD_EN
                    pass_d    = 1'b0;
`endif
                end
            end
            StRun: begin
                if (!last_op) begin
                    op_idx_d = 1'b1;
                end else begin
                    op_idx_d = 1'b0;
                    if (!addr_last) begin
                        step = 1'b1;
                    end else if (elem_q != LastElem) begin
                        elem_d    = elem_nxt;
                        load      = 1'b1;
                        load_down = ElemTable[elem_nxt].down;
`ifdef MBIST_CHECKERBOARD_EN
                    end else if (!pass_q) begin
                        pass_d    = 1'b1;
                        elem_d    = elem_nxt;
                        load      = 1'b1;
                        load_down = ElemTable[elem_nxt].down;
`endif
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // Memory pins depend only on registered state, never on start or mem_data_out.
    assign op_data     = op_is_one(cur_op) ? ~pat : pat;
    assign busy        = run || (state_q == StDrain);
    assign done        = (state_q == StDone);
    assign mem_wr_en   = run && !op_is_read(cur_op);
    assign mem_row     = run ? row : '0;
    assign mem_col     = run ? col : '0;
    assign mem_data_in = mem_wr_en ? op_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q      <= 1'b0;
            rd_row_q        <= '0;
            rd_col_q        <= '0;
            rd_exp_q        <= '0;
            fail            <= 1'b0;
            fail_count      <= '0;
            first_fail_row  <= '0;
            first_fail_col  <= '0;
            first_fail_data <= '0;
        end else begin
            rd_valid_q <= run && op_is_read(cur_op);
            rd_row_q   <= row;
            rd_col_q   <= col;
            rd_exp_q   <= op_data;
            if (clear) begin
                fail            <= 1'b0;
                fail_count      <= '0;
                first_fail_row  <= '0;
                first_fail_col  <= '0;
                first_fail_data <= '0;
            end else if (rd_valid_q && (mem_data_out != rd_exp_q)) begin
                fail <= 1'b1;
                if (fail_count != '1) begin
                    fail_count <= fail_count + FAIL_CNT_WIDTH'(1);
                end
                if (fail_count == '0) begin
                    first_fail_row  <= rd_row_q;
                    first_fail_col  <= rd_col_q;
                    first_fail_data <= mem_data_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: behavioural memories with stuck-at masks and a March C- reference model.
module tb_mbist_march_ctrl;
    localparam int N = 16;
`ifdef MBIST_CHECKERBOARD_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   start_cyc;
    logic cur;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: default parameters.
    logic       start_a, busy_a, done_a, fail_a, wr_a;
    logic [7:0] cnt_a, ffd_a, din_a, dout_a;
    logic [1:0] ffr_a, ffc_a, row_a, col_a;
    // DUT B: narrow fail counter.
    logic       start_b, busy_b, done_b, fail_b, wr_b;
    logic [3:0] cnt_b;
    logic [7:0] ffd_b, din_b, dout_b;
    logic [1:0] ffr_b, ffc_b, row_b, col_b;

    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    logic [7:0] sa1_a [16];
    logic [7:0] sa0_a [16];
    logic [7:0] sa1_b [16];
    logic [7:0] sa0_b [16];

    mbist_march_ctrl u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .fail(fail_a),
        .fail_count(cnt_a), .first_fail_row(ffr_a), .first_fail_col(ffc_a),
        .first_fail_data(ffd_a), .mem_wr_en(wr_a), .mem_row(row_a), .mem_col(col_a),
        .mem_data_in(din_a), .mem_data_out(dout_a)
    );

    mbist_march_ctrl #(.FAIL_CNT_WIDTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .fail(fail_b),
        .fail_count(cnt_b), .first_fail_row(ffr_b), .first_fail_col(ffc_b),
        .first_fail_data(ffd_b), .mem_wr_en(wr_b), .mem_row(row_b), .mem_col(col_b),
        .mem_data_in(din_b), .mem_data_out(dout_b)
    );

    always @(posedge clk) begin
        if (wr_a) mem_a[{row_a, col_a}] <= din_a;
        dout_a <= (mem_a[{row_a, col_a}] | sa1_a[{row_a, col_a}]) & ~sa0_a[{row_a, col_a}];
        if (wr_b) mem_b[{row_b, col_b}] <= din_b;
        dout_b <= (mem_b[{row_b, col_b}] | sa1_b[{row_b, col_b}]) & ~sa0_b[{row_b, col_b}];
    end

    logic       o_busy, o_done, o_fail, o_wr;
    logic [7:0] o_cnt, o_ffd, o_din;
    logic [1:0] o_ffr, o_ffc, o_row, o_col;
    assign o_busy = cur ? busy_b : busy_a;
    assign o_done = cur ? done_b : done_a;
    assign o_fail = cur ? fail_b : fail_a;
    assign o_cnt  = cur ? {4'b0, cnt_b} : cnt_a;
    assign o_ffr  = cur ? ffr_b : ffr_a;
    assign o_ffc  = cur ? ffc_b : ffc_a;
    assign o_ffd  = cur ? ffd_b : ffd_a;
    assign o_wr   = cur ? wr_b : wr_a;
    assign o_row  = cur ? row_b : row_a;
    assign o_col  = cur ? col_b : col_a;
    assign o_din  = cur ? din_b : din_a;

    // March C- reference: op codes 0=w0 1=w1 2=r0 3=r1.
    int nops [6] = '{1, 2, 2, 2, 2, 1};
    int op0  [6] = '{0, 2, 3, 2, 3, 2};
    int op1  [6] = '{0, 1, 0, 1, 0, 0};
    int dn   [6] = '{0, 0, 0, 1, 1, 0};

    typedef struct {
        int         lat;
        logic       fail;
        int         cnt;
        int         row;
        int         col;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t model(input logic s, input int cmax);
        logic [7:0] m [16];
        logic [7:0] pat, want, got;
        int a, code;
        exp_t e;
        e.lat = 10 * N * PASSES + 2;
        e.fail = 1'b0; e.cnt = 0; e.row = 0; e.col = 0; e.data = 8'h00;
        for (int p = 0; p < PASSES; p++)
            for (int el = 0; el < 6; el++)
                for (int i = 0; i < N; i++) begin
                    a = (dn[el] != 0) ? N - 1 - i : i;
                    pat = (p == 0) ? 8'h00 : ((((a >> 2) ^ a) & 1) != 0) ? 8'hAA : 8'h55;
                    for (int k = 0; k < nops[el]; k++) begin
                        code = (k == 0) ? op0[el] : op1[el];
                        want = code[0] ? ~pat : pat;
                        if (code < 2) begin
                            m[a] = want;
                        end else begin
                            got = s ? ((m[a] | sa1_b[a]) & ~sa0_b[a])
                                    : ((m[a] | sa1_a[a]) & ~sa0_a[a]);
                            if (got !== want) begin
                                if (e.cnt == 0) begin
                                    e.row = a >> 2; e.col = a & 3; e.data = got;
                                end
                                e.fail = 1'b1;
                                if (e.cnt < cmax) e.cnt++;
                            end
                        end
                    end
                end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_fail"}, o_fail, 0);
        check({tag, "_cnt"}, o_cnt, 0);
        check({tag, "_ffrow"}, o_ffr, 0);
        check({tag, "_ffcol"}, o_ffc, 0);
        check({tag, "_ffdata"}, o_ffd, 0);
        check({tag, "_wr"}, o_wr, 0);
        check({tag, "_row"}, o_row, 0);
        check({tag, "_col"}, o_col, 0);
        check({tag, "_din"}, o_din, 0);
    endtask

    task automatic run_test(input logic s, input int cmax, input int rp1, input int rp2,
                            input string tag);
        exp_t e;
        int lat, rel;
        bit seen;
        cur = s;
        sb.push_back(model(s, cmax));
        @(negedge clk);
        if (s) start_b = 1'b1; else start_a = 1'b1;
        start_cyc = cyc;
        seen = 1'b0;
        lat = -1;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            rel = cyc - start_cyc;
            start_a = !s && (rel == rp1 || rel == rp2);
            start_b = s && (rel == rp1 || rel == rp2);
            if (rel == 1) begin
                check({tag, "_busy_c1"}, o_busy, 1);
                check({tag, "_done_c1"}, o_done, 0);
                check({tag, "_wr_c1"}, o_wr, 1);
                check({tag, "_addr_c1"}, {o_row, o_col}, 0);
                check({tag, "_din_c1"}, o_din, 8'h00);
            end
`ifdef MBIST_CHECKERBOARD_EN
            if (rel == 10 * N + 1) begin
                check({tag, "_p2_addr0"}, {o_wr, o_row, o_col}, {1'b1, 4'd0});
                check({tag, "_p2_din0"}, o_din, 8'h55);
            end
            if (rel == 10 * N + 2) begin
                check({tag, "_p2_addr1"}, {o_wr, o_row, o_col}, {1'b1, 4'd1});
                check({tag, "_p2_din1"}, o_din, 8'hAA);
            end
`endif
            if (o_done) begin
                seen = 1'b1;
                lat = rel;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
        e = sb.pop_front();
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_latency"}, lat, e.lat);
        check({tag, "_busy_end"}, o_busy, 0);
        check({tag, "_fail"}, o_fail, e.fail);
        check({tag, "_count"}, o_cnt, e.cnt);
        check({tag, "_ffrow"}, o_ffr, e.row);
        check({tag, "_ffcol"}, o_ffc, e.col);
        check({tag, "_ffdata"}, o_ffd, e.data);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        cur = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sa1_a[i] = 8'h00; sa0_a[i] = 8'h00; sa1_b[i] = 8'h00; sa0_b[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check_idle("rst_a");
        cur = 1'b1;
        check_idle("rst_b");
        rst = 1'b0;

        run_test(1'b0, 255, -1, -1, "clean");

        sa1_a[6] = 8'h01;
        run_test(1'b0, 255, -1, -1, "sa1_r1c2");
        sa1_a[6] = 8'h00;

        run_test(1'b0, 255, 5, 50, "repulse");
        run_test(1'b0, 255, -1, -1, "rerun");

        // Abort a run with reset at cycle 80.
        cur = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start_a = 1'b0;
        while (cyc - start_cyc < 80) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("abort");
        seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (o_done || o_busy) seen = 1'b1;
        end
        check("abort_stays_idle", seen, 0);
        run_test(1'b0, 255, -1, -1, "after_abort");

        for (int i = 0; i < 16; i++) sa0_b[i] = 8'hFF;
        run_test(1'b1, 15, -1, -1, "sa0_all_sat");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
